// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: spreads each instruction over 3-5 states,
// with memory wait states, an illegal-opcode trap and a retired-instruction counter.
module multicycle_control #(
    parameter int unsigned OP_WIDTH     = 6,
    parameter int unsigned ALUOP_WIDTH  = 3,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter bit          ILLEGAL_TRAP = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_WIDTH-1:0]    OP,
    input  logic                   mem_ready,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   BranchNE,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic [1:0]             MemtoReg,
    output logic [1:0]             RegDst,
    output logic [2:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   illegal_op,
    output logic                   instr_retired,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, ALU_WB, LUI_WB,
        ADDR, MEM, MEM_WB, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'h00);
    localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'h02);
    localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(6'h03);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'h04);
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'h05);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'h08);
    localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'h0c);
    localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'h0d);
    localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'h0f);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'h23);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'h2b);

    localparam logic [ALUOP_WIDTH-1:0] ALU_AND   = ALUOP_WIDTH'(3'd0);
    localparam logic [ALUOP_WIDTH-1:0] ALU_OR    = ALUOP_WIDTH'(3'd1);
    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(3'd3);
    localparam logic [ALUOP_WIDTH-1:0] ALU_SUB   = ALUOP_WIDTH'(3'd4);
    localparam logic [ALUOP_WIDTH-1:0] ALU_LUI   = ALUOP_WIDTH'(3'd5);
    localparam logic [ALUOP_WIDTH-1:0] ALU_FUNCT = ALUOP_WIDTH'(3'd7);

    state_t               state;
    state_t               nextState;
    logic [OP_WIDTH-1:0]  opReg;
    logic [CNT_WIDTH-1:0] countReg;

    // State register, opcode latch and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            opReg    <= '0;
            countReg <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                opReg <= OP;
            end
            if (instr_retired) begin
                countReg <= countReg + CNT_WIDTH'(1);
            end
        end
    end

    assign instr_count = countReg;

    // Next-state logic; DECODE dispatches on the live opcode, later states on opReg
    always_comb begin
        nextState = state;
        case (state)
            IDLE:   nextState = FETCH;
            FETCH:  if (mem_ready) nextState = DECODE;
            DECODE: begin
                case (OP)
                    OP_R, OP_ADDI, OP_ORI, OP_ANDI: nextState = EXEC;
                    OP_LUI:                         nextState = LUI_WB;
                    OP_LW, OP_SW:                   nextState = ADDR;
                    OP_BEQ, OP_BNE:                 nextState = BRANCH;
                    OP_J, OP_JAL:                   nextState = JUMP;
                    default:                        nextState = TRAP;
                endcase
            end
            EXEC:   nextState = ALU_WB;
            ALU_WB: nextState = FETCH;
            LUI_WB: nextState = FETCH;
            ADDR:   nextState = MEM;
            MEM: begin
                if (mem_ready) begin
                    nextState = (opReg == OP_LW) ? MEM_WB : FETCH;
                end
            end
            MEM_WB: nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            TRAP:   nextState = ILLEGAL_TRAP ? TRAP : FETCH;
            default: nextState = IDLE;
        endcase
    end

    // Control outputs decoded from state, latched opcode and mem_ready
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        BranchNE      = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        MemtoReg      = 2'b00;
        RegDst        = 2'b00;
        ALUSrcB       = 3'b000;
        PCSource      = 2'b00;
        ALUOp         = ALU_AND;
        illegal_op    = 1'b0;
        instr_retired = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 3'b001;
                ALUOp   = ALU_ADD;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 3'b011;
                ALUOp   = ALU_ADD;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                case (opReg)
                    OP_R: begin
                        ALUSrcB = 3'b000;
                        ALUOp   = ALU_FUNCT;
                    end
                    OP_ADDI: begin
                        ALUSrcB = 3'b010;
                        ALUOp   = ALU_ADD;
                    end
                    OP_ORI: begin
                        ALUSrcB = 3'b100;
                        ALUOp   = ALU_OR;
                    end
                    OP_ANDI: begin
                        ALUSrcB = 3'b100;
                        ALUOp   = ALU_AND;
                    end
                    default: ALUSrcB = 3'b000;
                endcase
            end
            ALU_WB: begin
                RegWrite      = 1'b1;
                RegDst        = (opReg == OP_R) ? 2'b01 : 2'b00;
                instr_retired = 1'b1;
            end
            LUI_WB: begin
                RegWrite      = 1'b1;
                MemtoReg      = 2'b11;
                ALUOp         = ALU_LUI;
                instr_retired = 1'b1;
            end
            ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 3'b010;
                ALUOp   = ALU_ADD;
            end
            MEM: begin
                IorD          = 1'b1;
                MemRead       = (opReg == OP_LW);
                MemWrite      = (opReg == OP_SW);
                instr_retired = mem_ready && (opReg != OP_LW);
            end
            MEM_WB: begin
                RegWrite      = 1'b1;
                MemtoReg      = 2'b01;
                instr_retired = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                BranchNE      = (opReg == OP_BNE);
                instr_retired = 1'b1;
            end
            JUMP: begin
                PCWrite       = 1'b1;
                PCSource      = 2'b10;
                instr_retired = 1'b1;
                if (opReg == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            TRAP: begin
                illegal_op    = 1'b1;
                instr_retired = !ILLEGAL_TRAP;
            end
            default: illegal_op = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle expectations are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset, reset0;
    logic [5:0] OP, OP0;
    logic       mem_ready, mem_ready0;

    logic PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] MemtoReg, RegDst, PCSource;
    logic [2:0] ALUSrcB, ALUOp;
    logic illegal_op, instr_retired;
    logic [31:0] instr_count;

    logic PCWrite0, PCWriteCond0, BranchNE0, IorD0, MemRead0, MemWrite0, IRWrite0, RegWrite0, ALUSrcA0;
    logic [1:0] MemtoReg0, RegDst0, PCSource0;
    logic [2:0] ALUSrcB0, ALUOp0;
    logic illegal_op0, instr_retired0;
    logic [31:0] instr_count0;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .instr_retired(instr_retired), .instr_count(instr_count)
    );

    multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset0), .OP(OP0), .mem_ready(mem_ready0),
        .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0), .BranchNE(BranchNE0), .IorD(IorD0),
        .MemRead(MemRead0), .MemWrite(MemWrite0), .IRWrite(IRWrite0), .RegWrite(RegWrite0),
        .ALUSrcA(ALUSrcA0), .MemtoReg(MemtoReg0), .RegDst(RegDst0), .ALUSrcB(ALUSrcB0),
        .PCSource(PCSource0), .ALUOp(ALUOp0), .illegal_op(illegal_op0),
        .instr_retired(instr_retired0), .instr_count(instr_count0)
    );

    wire [22:0] vec1 = {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                        RegWrite, ALUSrcA, MemtoReg, RegDst, ALUSrcB, PCSource, ALUOp,
                        illegal_op, instr_retired};
    wire [22:0] vec0 = {PCWrite0, PCWriteCond0, BranchNE0, IorD0, MemRead0, MemWrite0, IRWrite0,
                        RegWrite0, ALUSrcA0, MemtoReg0, RegDst0, ALUSrcB0, PCSource0, ALUOp0,
                        illegal_op0, instr_retired0};

    typedef struct {
        logic [22:0] ctrl;
        logic [31:0] cnt;
        bit          sel;
        string       name;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [22:0] mk(input bit pcw, pcwc, bne, iord, mr, mw, irw, rw, asa,
                                       input logic [1:0] m2r, rd, input logic [2:0] asb,
                                       input logic [1:0] pcs, input logic [2:0] aop,
                                       input bit ill, ret);
        return {pcw, pcwc, bne, iord, mr, mw, irw, rw, asa, m2r, rd, asb, pcs, aop, ill, ret};
    endfunction

    // Monitor: every cycle with a queued expectation, compare the selected DUT
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [22:0] act;
            logic [31:0] cnt;
            e   = q.pop_front();
            act = e.sel ? vec0 : vec1;
            cnt = e.sel ? instr_count0 : instr_count;
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl: got %06h required %06h", e.name, act, e.ctrl);
            end
            checks++;
            if (cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s count: got %0d required %0d", e.name, cnt, e.cnt);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle
    task automatic step(input bit sel, input bit rst, input logic [5:0] op, input bit mr,
                        input logic [22:0] ctrl, input logic [31:0] cnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel) begin
            reset0 = rst; OP0 = op; mem_ready0 = mr;
        end else begin
            reset = rst; OP = op; mem_ready = mr;
        end
        e.ctrl = ctrl; e.cnt = cnt; e.sel = sel; e.name = name;
        q.push_back(e);
    endtask

    initial begin
        logic [22:0] z, fetchRdy, fetchWait, dec, addr;
        z         = '0;
        fetchRdy  = mk(1,0,0,0,1,0,1,0,0, 2'b00,2'b00,3'b001,2'b00,3'd3, 0,0);
        fetchWait = mk(0,0,0,0,1,0,0,0,0, 2'b00,2'b00,3'b001,2'b00,3'd3, 0,0);
        dec       = mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,3'b011,2'b00,3'd3, 0,0);
        addr      = mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b010,2'b00,3'd3, 0,0);

        reset = 1'b1; OP = 6'h00; mem_ready = 1'b0;
        reset0 = 1'b1; OP0 = 6'h00; mem_ready0 = 1'b0;
        @(posedge clk);

        step(0, 1, 6'h00, 1, z, 0, "reset");
        // R-type
        step(0, 0, 6'h00, 1, z, 0, "r_idle");
        step(0, 0, 6'h00, 1, fetchRdy, 0, "r_fetch");
        step(0, 0, 6'h00, 1, dec, 0, "r_decode");
        step(0, 0, 6'h3f, 1, mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b00,3'd7, 0,0), 0, "r_exec");
        step(0, 0, 6'h3f, 1, mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b01,3'b000,2'b00,3'd0, 0,1), 0, "r_alu_wb");
        // LW with two wait cycles in MEM; OP garbled after DECODE
        step(0, 0, 6'h23, 1, fetchRdy, 1, "lw_fetch");
        step(0, 0, 6'h23, 1, dec, 1, "lw_decode");
        step(0, 0, 6'h2b, 1, addr, 1, "lw_addr");
        step(0, 0, 6'h2b, 0, mk(0,0,0,1,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 0,0), 1, "lw_mem_w1");
        step(0, 0, 6'h2b, 0, mk(0,0,0,1,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 0,0), 1, "lw_mem_w2");
        step(0, 0, 6'h2b, 1, mk(0,0,0,1,1,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 0,0), 1, "lw_mem_done");
        step(0, 0, 6'h2b, 1, mk(0,0,0,0,0,0,0,1,0, 2'b01,2'b00,3'b000,2'b00,3'd0, 0,1), 1, "lw_mem_wb");
        // BNE
        step(0, 0, 6'h05, 1, fetchRdy, 2, "bne_fetch");
        step(0, 0, 6'h05, 1, dec, 2, "bne_decode");
        step(0, 0, 6'h05, 1, mk(0,1,1,0,0,0,0,0,1, 2'b00,2'b00,3'b000,2'b01,3'd4, 0,1), 2, "bne_branch");
        // JAL
        step(0, 0, 6'h03, 1, fetchRdy, 3, "jal_fetch");
        step(0, 0, 6'h03, 1, dec, 3, "jal_decode");
        step(0, 0, 6'h03, 1, mk(1,0,0,0,0,0,0,1,0, 2'b10,2'b10,3'b000,2'b10,3'd0, 0,1), 3, "jal_jump");
        // ORI
        step(0, 0, 6'h0d, 1, fetchRdy, 4, "ori_fetch");
        step(0, 0, 6'h0d, 1, dec, 4, "ori_decode");
        step(0, 0, 6'h0d, 1, mk(0,0,0,0,0,0,0,0,1, 2'b00,2'b00,3'b100,2'b00,3'd1, 0,0), 4, "ori_exec");
        step(0, 0, 6'h0d, 1, mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 0,1), 4, "ori_alu_wb");
        // LUI with one fetch wait state
        step(0, 0, 6'h0f, 0, fetchWait, 5, "lui_fetch_wait");
        step(0, 0, 6'h0f, 1, fetchRdy, 5, "lui_fetch");
        step(0, 0, 6'h0f, 1, dec, 5, "lui_decode");
        step(0, 0, 6'h0f, 1, mk(0,0,0,0,0,0,0,1,0, 2'b11,2'b00,3'b000,2'b00,3'd5, 0,1), 5, "lui_wb");
        // SW interrupted by reset while waiting in MEM
        step(0, 0, 6'h2b, 1, fetchRdy, 6, "sw_fetch");
        step(0, 0, 6'h2b, 1, dec, 6, "sw_decode");
        step(0, 0, 6'h2b, 0, addr, 6, "sw_addr");
        step(0, 1, 6'h2b, 0, mk(0,0,0,1,0,1,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 0,0), 6, "sw_mem_reset");
        step(0, 0, 6'h2b, 1, z, 0, "sw_after_reset");
        // Illegal opcode, trapping instance
        step(0, 0, 6'h3f, 1, fetchRdy, 0, "trap_fetch");
        step(0, 0, 6'h3f, 1, dec, 0, "trap_decode");
        for (int i = 0; i < 22; i++) begin
            step(0, 0, 6'h00, 1, mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 1,0), 0, "trap_hold");
        end
        step(0, 1, 6'h00, 1, mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 1,0), 0, "trap_reset");
        step(0, 0, 6'h00, 1, z, 0, "trap_cleared");

        // Illegal opcode, NOP instance (held in reset until now)
        step(1, 1, 6'h00, 1, z, 0, "nop_reset");
        step(1, 0, 6'h00, 1, z, 0, "nop_idle");
        step(1, 0, 6'h3f, 1, fetchRdy, 0, "nop_fetch");
        step(1, 0, 6'h3f, 1, dec, 0, "nop_decode");
        step(1, 0, 6'h00, 1, mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,3'b000,2'b00,3'd0, 1,1), 0, "nop_trap");
        step(1, 0, 6'h00, 0, fetchWait, 1, "nop_refetch");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control FSM for the MIPS datapath, replacing the single-cycle opcode decoder with a sequencer that spreads each instruction over 3–5 states. It sits between the instruction register (opcode field) and the shared-memory multicycle datapath. It adds memory wait-state handshaking, an illegal-opcode trap and a retired-instruction counter, while keeping the same opcode set and ALU operation encoding.

## Interface
- OP_WIDTH, 6, opcode field width (Instruction[31:26]).
- ALUOP_WIDTH, 3, ALUOp width, ≥3; codes zero-extended (AND 0, OR 1, NOR 2, ADD 3, SUB 4, LUI 5, FUNCT 7).
- CNT_WIDTH, 32, retired-instruction counter width.
- ILLEGAL_TRAP, 1, 1: unknown opcode halts in TRAP; 0: treated as NOP (back to FETCH).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- OP  in  OP_WIDTH  opcode from IR, valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each.
- MemtoReg  out  2  00 ALU out, 01 MDR, 10 PC+4, 11 LUI imm.
- RegDst  out  2  00 rt, 01 rd, 10 ra.
- ALUSrcB  out  3  000 B, 001 const 4, 010 sign-ext, 011 sign-ext<<2, 100 zero-ext.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump address.
- ALUOp  out  ALUOP_WIDTH.
- illegal_op  out  1  high while in TRAP.
- instr_retired  out  1  one-cycle pulse on each instruction's final state.
- instr_count  out  CNT_WIDTH  retired count.

## Operation
- Outputs are combinational from state (plus latched opcode, plus mem_ready where noted). Every output not listed for a state is 0.
- Opcode is latched into an internal register in DECODE; later states use the latched copy, not OP.
- States and transitions:
  - IDLE: no outputs asserted -> FETCH.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=001, ALUOp=ADD.
    - If mem_ready: IRWrite=1, PCWrite=1, PCSource=00 -> DECODE. Otherwise stay.
  - DECODE: ALUSrcA=0, ALUSrcB=011, ALUOp=ADD. Next state:
    - R(0x00), ADDI(0x08), ORI(0x0d), ANDI(0x0c) -> EXEC.
    - LUI(0x0f) -> LUI_WB.
    - LW(0x23), SW(0x2b) -> ADDR.
    - BEQ(0x04), BNE(0x05) -> BRANCH.
    - J(0x02), JAL(0x03) -> JUMP.
    - Other opcodes -> TRAP.
  - EXEC: ALUSrcA=1 -> ALU_WB.
    - R: ALUSrcB=000, ALUOp=FUNCT.
    - ADDI: ALUSrcB=010, ALUOp=ADD.
    - ORI: ALUSrcB=100, ALUOp=OR.
    - ANDI: ALUSrcB=100, ALUOp=AND.
  - ALU_WB: RegWrite=1, MemtoReg=00, RegDst=01 for R else 00; retires -> FETCH.
  - LUI_WB: RegWrite=1, MemtoReg=11, RegDst=00, ALUOp=LUI; retires -> FETCH.
  - ADDR: ALUSrcA=1, ALUSrcB=010, ALUOp=ADD -> MEM.
  - MEM: IorD=1; MemRead=1 (LW) or MemWrite=1 (SW). Wait for mem_ready; then LW -> MEM_WB, SW retires -> FETCH.
  - MEM_WB: RegWrite=1, MemtoReg=01, RegDst=00; retires -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=000, ALUOp=SUB, PCWriteCond=1, PCSource=01, BranchNE=(op==BNE); retires -> FETCH.
  - JUMP: PCWrite=1, PCSource=10; JAL also RegWrite=1, RegDst=10, MemtoReg=10; retires -> FETCH.
  - TRAP: illegal_op=1. With ILLEGAL_TRAP=1, stay until reset; with 0, retire as NOP -> FETCH (illegal_op pulses one cycle).
- instr_count increments by 1 on every instr_retired and wraps modulo 2^CNT_WIDTH.

## Timing
- Reset (sync): state=IDLE, latched op=0, instr_count=0. All outputs 0 in the cycle after reset is sampled.
  - Reset wins over every transition, including mid-MEM and TRAP.
  - An in-flight write is dropped: MemWrite falls the cycle after reset.
- First FETCH occurs 1 cycle after reset deassertion (IDLE).
- Cycles per instruction with mem_ready=1: R/ADDI/ORI/ANDI 4, LW 5, SW 4, LUI 3, BEQ/BNE 3, J/JAL 3.
- Each cycle mem_ready=0 in FETCH or MEM adds one cycle. IRWrite/PCWrite in FETCH and the MEM exit are gated by mem_ready in the same cycle.
- mem_ready is ignored outside FETCH and MEM.
- instr_retired is coincident with the retiring state; instr_count shows the new value one cycle later.

## Test plan
- Reset, then R-type op=0x00 with mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC, ALU_WB; RegWrite=1, RegDst=01 in cycle 5; instr_count=1 after.
- LW op=0x23 with mem_ready low for 2 cycles in MEM -> MemRead=1, IorD=1 held for 3 cycles; MEM_WB gives MemtoReg=01; total 7 cycles.
- BNE op=0x05 -> BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=SUB, PCSource=01; 3 cycles.
- JAL op=0x03 -> JUMP with PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
- op=0x3f with ILLEGAL_TRAP=1 -> illegal_op stays high for 20+ cycles, instr_count unchanged. With ILLEGAL_TRAP=0 -> one-cycle pulse, then FETCH, count+1.
- SW with mem_ready=0, reset asserted during MEM -> MemWrite low next cycle, state IDLE, instr_count=0.
